spi_responder: RTL

SPI responder (slave) for the FPGA fabric, the far end of the SD/SPI initiator path. It lets an external SPI master, such as a host MCU or a second board, exchange fixed-width words with on-chip logic. The block oversamples the SPI pins in the system clock domain and works in mode 0 (CPOL=0, CPHA=0), MSB first. Received words come out as one-cycle pulses; words to transmit are accepted through a valid/ready handshake into a one-entry holding register.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync.sv | 46 ++++
 rtl/spi_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI responder: bus mode, idle fill
// value and the bit-counter sizing function.
package spi_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam logic FILL_BIT = 1'b1;

  function automatic int bitcnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with registered
// rise/fall strobes aligned to the synchronized level.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES = 2,
  parameter logic IDLE   = SPI_CPOL
) (
  input  logic clock,
  input  logic reset,
  input  logic in_pin,
  output logic out_sync,
  output logic out_rise,
  output logic out_fall
);

  logic [STAGES-1:0] stage_q, stage_d;
  logic [STAGES:0]   chain;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Strobes look one stage ahead so they assert together with the new level.
  always_comb begin
    chain   = {stage_q, in_pin};
    stage_d = chain[STAGES-1:0];
    rise_d  = chain[STAGES-1] & ~chain[STAGES];
    fall_d  = ~chain[STAGES-1] & chain[STAGES];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= {STAGES{IDLE}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out_sync = stage_q[STAGES-1];
  assign out_rise = rise_q;
  assign out_fall = fall_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples the SPI pins in the system clock domain,
// exchanges WIDTH-bit words MSB first, one-entry transmit holding register.
module spi_responder
  import spi_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] FILL        = {WIDTH{FILL_BIT}},
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_sclk,
  input  logic             in_cs_n,
  input  logic             in_mosi,
  output logic             out_miso_0,
  output logic             out_miso_en,
  input  logic             in_tx_valid,
  input  logic [WIDTH-1:0] in_tx_data,
  output logic             out_tx_ready,
  output logic             out_rx_valid,
  output logic [WIDTH-1:0] out_rx_data,
  output logic             out_abort,
  output logic             out_busy
);

  localparam int               CNT_W          = bitcnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT       = CNT_W'(WIDTH - 1);
  localparam logic             SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(SPI_CPOL)) u_sync_sclk (
    .clock(clock), .reset(reset), .in_pin(in_sclk),
    .out_sync(sclk_level_unused), .out_rise(sclk_rise), .out_fall(sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset), .in_pin(in_cs_n),
    .out_sync(cs_level_unused), .out_rise(cs_rise), .out_fall(cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .in_pin(in_mosi),
    .out_sync(mosi_sync), .out_rise(mosi_rise_unused), .out_fall(mosi_fall_unused)
  );

  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic             miso_en_q, miso_en_d;
  logic             busy_q, busy_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             abort_q, abort_d;

  logic [WIDTH-1:0] load_word, rx_shift;
  logic             load, sample_evt, shift_evt;

  // busy_q gates sclk events, so a CS rise still lets its coincident sclk
  // edge complete, and a CS fall wins over any sclk edge in its cycle.
  always_comb begin
    tx_d       = tx_q;
    rx_d       = rx_q;
    hold_d     = hold_q;
    full_d     = full_q;
    bitcnt_d   = bitcnt_q;
    miso_en_d  = miso_en_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    abort_d    = 1'b0;
    load       = 1'b0;
    load_word  = full_q ? hold_q : FILL;
    rx_shift   = {rx_q[WIDTH-2:0], mosi_sync};
    sample_evt = SAMPLE_ON_FALL ? sclk_fall : sclk_rise;
    shift_evt  = SAMPLE_ON_FALL ? sclk_rise : sclk_fall;

    if (cs_fall) begin
      bitcnt_d  = '0;
      tx_d      = load_word;
      load      = 1'b1;
      miso_en_d = 1'b1;
      busy_d    = 1'b1;
    end else begin
      if (busy_q && sample_evt) begin
        rx_d = rx_shift;
        if (bitcnt_q == LAST_BIT) begin
          bitcnt_d   = '0;
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
        end else begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      if (busy_q && shift_evt) begin
        if (bitcnt_q == '0) begin
          tx_d = load_word;
          load = 1'b1;
        end else begin
          tx_d = {tx_q[WIDTH-2:0], 1'b0};
        end
      end
      if (cs_rise) begin
        miso_en_d = 1'b0;
        busy_d    = 1'b0;
        if (bitcnt_d != '0) begin
          abort_d  = 1'b1;
          bitcnt_d = '0;
        end
      end
    end

    if (load) begin
      full_d = 1'b0;
    end
    if (in_tx_valid && !full_q) begin
      hold_d = in_tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q       <= FILL;
      rx_q       <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      bitcnt_q   <= '0;
      miso_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      bitcnt_q   <= bitcnt_d;
      miso_en_q  <= miso_en_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      abort_q    <= abort_d;
    end
  end

  assign out_miso_0   = tx_q[WIDTH-1];
  assign out_miso_en  = miso_en_q;
  assign out_tx_ready = !full_q;
  assign out_rx_valid = rx_valid_q;
  assign out_rx_data  = rx_data_q;
  assign out_abort    = abort_q;
  assign out_busy     = busy_q;

endmodule
